// File: rtl/pmem_pkg.sv
// Shared types and helpers for the multi-port physical-memory model.
package pmem_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_e;
   typedef enum logic {OP_RD, OP_WR} pmem_op_e;

   // Wide enough for up to 256 request channels.
   localparam int CH_IDX_W = 8;
   typedef logic [CH_IDX_W-1:0] ch_idx_t;

   function automatic int ofs_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/pmem_if.sv
// Request/response bundle between NUM_CH requestors (master) and pmem_multiport (slave).
interface pmem_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 16,
   parameter int LINE_W = 128
);
   logic [NUM_CH-1:0]        pmem_read;
   logic [NUM_CH-1:0]        pmem_write;
   logic [NUM_CH*ADDR_W-1:0] pmem_address;
   logic [NUM_CH*LINE_W-1:0] pmem_wdata;
   logic [NUM_CH-1:0]        pmem_resp;
   logic [NUM_CH*LINE_W-1:0] pmem_rdata;

   modport master (
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );

   modport slave (
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/pmem_rr_arb.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping mod NUM_CH.
module pmem_rr_arb
   import pmem_pkg::*;
#(
   parameter int NUM_CH = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  ch_idx_t           ptr,
   output logic              gnt_valid,
   output ch_idx_t           gnt_idx
);

   int idx;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      idx       = 0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = ch_idx_t'(idx);
         end
      end
   end

endmodule

// File: rtl/pmem_multiport.sv
// Multi-channel physical-memory model: round-robin arbitration, one fixed-latency access in flight.
// Optional performance counters are built when PMEM_PERF_EN is defined.
module pmem_multiport
   import pmem_pkg::*;
#(
   parameter int NUM_CH  = 2,
   parameter int ADDR_W  = 16,
   parameter int LINE_W  = 128,
   parameter int LATENCY = 25
) (
   input  logic        clk,
   input  logic        rst,
   pmem_if.slave       bus,
   output logic [31:0] perf_reads,
   output logic [31:0] perf_writes,
   output logic [31:0] perf_stalls
);

   localparam int OFS_W = ofs_w(LINE_W);
   localparam int IDX_W = ADDR_W - OFS_W;
   localparam int CNT_W = $clog2(LATENCY + 1);

   pmem_state_e       state_q, state_d;
   ch_idx_t           rr_ptr_q, ch_q, gnt_idx;
   pmem_op_e          op_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  idx_q, sel_idx;
   logic [LINE_W-1:0] wdata_q, sel_wdata, rdata_q;
   logic [NUM_CH-1:0] req, resp_q, resp_d;
   logic              gnt_valid, sel_wr, commit;

   logic [LINE_W-1:0] mem [2**IDX_W];

   assign req    = bus.pmem_read | bus.pmem_write;
   assign commit = (state_q == BUSY) && (cnt_q == '0);

   pmem_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .req       (req),
      .ptr       (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // Mux the granted channel's request fields; write wins over read on the same channel.
   always_comb begin
      sel_wr    = 1'b0;
      sel_idx   = '0;
      sel_wdata = '0;
      resp_d    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt_idx == ch_idx_t'(i)) begin
            sel_wr    = bus.pmem_write[i];
            sel_idx   = bus.pmem_address[i*ADDR_W+OFS_W +: IDX_W];
            sel_wdata = bus.pmem_wdata[i*LINE_W +: LINE_W];
         end
         if (ch_q == ch_idx_t'(i)) resp_d[i] = 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (gnt_valid) state_d = BUSY;
         BUSY:    if (cnt_q == '0) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
         ch_q     <= '0;
         op_q     <= OP_RD;
         resp_q   <= '0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  ch_q  <= gnt_idx;
                  op_q  <= sel_wr ? OP_WR : OP_RD;
                  cnt_q <= CNT_W'(LATENCY - 1);
               end
            end
            BUSY: begin
               if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
               if (commit) begin
                  resp_q <= resp_d;
                  if (op_q == OP_RD) rdata_q <= mem[idx_q];
               end
            end
            RESP: begin
               resp_q   <= '0;
               rdata_q  <= '0;
               rr_ptr_q <= (ch_q == ch_idx_t'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Latched request data; only meaningful while a transaction is in flight.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && gnt_valid) begin
         idx_q   <= sel_idx;
         wdata_q <= sel_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && commit && op_q == OP_WR) mem[idx_q] <= wdata_q;
   end

   assign bus.pmem_resp = resp_q;

   always_comb begin
      bus.pmem_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == ch_idx_t'(i)) bus.pmem_rdata[i*LINE_W +: LINE_W] = rdata_q;
      end
   end

`ifdef PMEM_PERF_EN
   logic [31:0] reads_q, writes_q, stalls_q, stall_add;

   // Requesters waiting behind the in-flight channel.
   always_comb begin
      stall_add = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[i] && ch_q != ch_idx_t'(i)) stall_add = stall_add + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reads_q  <= '0;
         writes_q <= '0;
         stalls_q <= '0;
      end else begin
         if (state_q == RESP) begin
            if (op_q == OP_WR) writes_q <= writes_q + 32'd1;
            else               reads_q  <= reads_q + 32'd1;
         end
         if (state_q != IDLE) stalls_q <= stalls_q + stall_add;
      end
   end

   assign perf_reads  = reads_q;
   assign perf_writes = writes_q;
   assign perf_stalls = stalls_q;
`else
   assign perf_reads  = 32'd0;
   assign perf_writes = 32'd0;
   assign perf_stalls = 32'd0;
`endif

endmodule

// File: tb/tb_pmem_multiport.sv
// Directed bench for pmem_multiport (NUM_CH=2, LATENCY=25); perf checks follow PMEM_PERF_EN.
module tb_pmem_multiport;

   localparam int NUM_CH  = 2;
   localparam int ADDR_W  = 16;
   localparam int LINE_W  = 128;
   localparam int LATENCY = 25;
   localparam logic [127:0] PAT_A5 = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] perf_reads, perf_writes, perf_stalls;
   int          checks = 0;
   int          failures = 0;

   pmem_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   pmem_multiport #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .LATENCY(LATENCY)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .perf_reads  (perf_reads),
      .perf_writes (perf_writes),
      .perf_stalls (perf_stalls)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.pmem_read    = '0;
      bus.pmem_write   = '0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = '0;
   endtask

   // op: 0 read, 1 write, 2 read and write together
   task automatic drive_ch(input int ch, input int op, input logic [15:0] addr,
                           input logic [127:0] wd);
      bus.pmem_read[ch]                     = (op == 0 || op == 2);
      bus.pmem_write[ch]                    = (op >= 1);
      bus.pmem_address[ch*ADDR_W +: ADDR_W] = addr;
      bus.pmem_wdata[ch*LINE_W +: LINE_W]   = wd;
   endtask

   // Runs one transaction from IDLE and returns what was observed at the resp pulse.
   task automatic run_txn(input int ch, input int op, input logic [15:0] addr,
                          input logic [127:0] wd, input int drop_after,
                          output int lat, output logic [1:0] resp_v,
                          output logic [127:0] rd_own, output logic [127:0] rd_other,
                          output logic [1:0] resp_after);
      lat = 0;
      resp_v = '0;
      rd_own = '0;
      rd_other = '0;
      drive_ch(ch, op, addr, wd);
      while (lat <= 100) begin
         step();
         lat++;
         if (lat == drop_after) idle_bus();
         if (bus.pmem_resp != '0) break;
      end
      if (lat > 100) lat = -1;
      resp_v   = bus.pmem_resp;
      rd_own   = bus.pmem_rdata[ch*LINE_W +: LINE_W];
      rd_other = bus.pmem_rdata[(1-ch)*LINE_W +: LINE_W];
      idle_bus();
      step();
      resp_after = bus.pmem_resp;
   endtask

   task automatic test_reset();
      idle_bus();
      rst = 1'b1;
      step();
      step();
      if (bus.pmem_resp !== 2'b00) begin
         failures++; $display("FAIL reset_resp got=%b exp=00", bus.pmem_resp);
      end
      checks++;
      if (bus.pmem_rdata !== '0) begin
         failures++; $display("FAIL reset_rdata got=%h exp=0", bus.pmem_rdata);
      end
      checks++;
      if ({perf_reads, perf_writes, perf_stalls} !== 96'd0) begin
         failures++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0",
                              perf_reads, perf_writes, perf_stalls);
      end
      checks++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_read();
      int lat;
      logic [1:0] rv, ra;
      logic [127:0] own, oth;
      run_txn(1, 1, 16'h0100, PAT_A5, 0, lat, rv, own, oth, ra);
      if (lat !== 26 || rv !== 2'b10) begin
         failures++; $display("FAIL preload_wr got=lat%0d/resp%b exp=lat26/resp10", lat, rv);
      end
      checks++;
      run_txn(0, 0, 16'h0100, '0, 0, lat, rv, own, oth, ra);
      if (lat !== 26) begin
         failures++; $display("FAIL single_rd_lat got=%0d exp=26", lat);
      end
      checks++;
      if (rv !== 2'b01) begin
         failures++; $display("FAIL single_rd_resp got=%b exp=01", rv);
      end
      checks++;
      if (own !== PAT_A5) begin
         failures++; $display("FAIL single_rd_data got=%h exp=%h", own, PAT_A5);
      end
      checks++;
      if (oth !== '0) begin
         failures++; $display("FAIL single_rd_other got=%h exp=0", oth);
      end
      checks++;
      if (ra !== 2'b00) begin
         failures++; $display("FAIL single_rd_pulse got=%b exp=00", ra);
      end
      checks++;
   endtask

   task automatic test_write_read();
      int lat;
      logic [1:0] rv, ra;
      logic [127:0] own, oth;
      run_txn(1, 1, 16'h0FF0, 128'h1234, 0, lat, rv, own, oth, ra);
      if (own !== '0 || rv !== 2'b10) begin
         failures++; $display("FAIL wr_resp got=resp%b/rdata%h exp=resp10/rdata0", rv, own);
      end
      checks++;
      run_txn(1, 0, 16'h0FFF, '0, 0, lat, rv, own, oth, ra);
      if (own !== 128'h1234 || rv !== 2'b10) begin
         failures++; $display("FAIL wr_rd_offset got=%h/%b exp=1234/10", own, rv);
      end
      checks++;
      run_txn(0, 0, 16'h0FF0, '0, 0, lat, rv, own, oth, ra);
      if (own !== 128'h1234) begin
         failures++; $display("FAIL wr_rd_ch0 got=%h exp=1234", own);
      end
      checks++;
      run_txn(0, 2, 16'h0300, 128'hBEEF, 0, lat, rv, own, oth, ra);
      run_txn(1, 0, 16'h0300, '0, 0, lat, rv, own, oth, ra);
      if (own !== 128'hBEEF) begin
         failures++; $display("FAIL rdwr_as_write got=%h exp=beef", own);
      end
      checks++;
   endtask

   task automatic test_contention();
      int t[4];
      logic [1:0] v[4];
      logic [127:0] d[4];
      int n, cyc;
      idle_bus();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      drive_ch(0, 0, 16'h0100, '0);
      drive_ch(1, 0, 16'h0FF0, '0);
      n = 0;
      cyc = 0;
      while (n < 4 && cyc < 200) begin
         step();
         cyc++;
         if (bus.pmem_resp != '0) begin
            t[n] = cyc;
            v[n] = bus.pmem_resp;
            d[n] = (bus.pmem_resp == 2'b01) ? bus.pmem_rdata[127:0] : bus.pmem_rdata[255:128];
            n++;
            if (n == 4) idle_bus();
         end
      end
      if (n !== 4) begin
         failures++; $display("FAIL cont_count got=%0d exp=4", n);
      end
      checks++;
      for (int i = 0; i < n; i++) begin
         if (v[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            failures++; $display("FAIL cont_order[%0d] got=%b exp=%b", i, v[i],
                                 (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         checks++;
         if (t[i] !== 26 + 27 * i) begin
            failures++; $display("FAIL cont_time[%0d] got=%0d exp=%0d", i, t[i], 26 + 27 * i);
         end
         checks++;
         if (d[i] !== ((i % 2 == 0) ? PAT_A5 : 128'h1234)) begin
            failures++; $display("FAIL cont_data[%0d] got=%h", i, d[i]);
         end
         checks++;
      end
      step();
`ifdef PMEM_PERF_EN
      if (perf_reads !== 32'd4 || perf_writes !== 32'd0) begin
         failures++; $display("FAIL perf_rw got=%0d/%0d exp=4/0", perf_reads, perf_writes);
      end
      checks++;
      if (perf_stalls !== 32'd103) begin
         failures++; $display("FAIL perf_stalls got=%0d exp=103", perf_stalls);
      end
      checks++;
`else
      if ({perf_reads, perf_writes, perf_stalls} !== 96'd0) begin
         failures++; $display("FAIL perf_off got=%0d/%0d/%0d exp=0/0/0",
                              perf_reads, perf_writes, perf_stalls);
      end
      checks++;
`endif
   endtask

   task automatic test_reset_mid_write();
      int lat, seen;
      logic [1:0] rv, ra;
      logic [127:0] own, oth;
      run_txn(0, 1, 16'h0200, 128'h5555, 0, lat, rv, own, oth, ra);
      drive_ch(0, 1, 16'h0200, 128'hDEAD);
      seen = 0;
      for (int i = 0; i < 11; i++) begin
         step();
         if (bus.pmem_resp != '0) seen++;
      end
      rst = 1'b1;
      idle_bus();
      step();
      if (bus.pmem_resp !== 2'b00 || bus.pmem_rdata !== '0) begin
         failures++; $display("FAIL midrst_out got=%b/%h exp=00/0", bus.pmem_resp, bus.pmem_rdata);
      end
      checks++;
      if ({perf_reads, perf_writes, perf_stalls} !== 96'd0) begin
         failures++; $display("FAIL midrst_perf got=%0d/%0d/%0d exp=0/0/0",
                              perf_reads, perf_writes, perf_stalls);
      end
      checks++;
      rst = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (bus.pmem_resp != '0) seen++;
      end
      if (seen !== 0) begin
         failures++; $display("FAIL midrst_noresp got=%0d exp=0", seen);
      end
      checks++;
      run_txn(0, 0, 16'h0200, '0, 0, lat, rv, own, oth, ra);
      if (own !== 128'h5555) begin
         failures++; $display("FAIL midrst_line got=%h exp=5555", own);
      end
      checks++;
   endtask

   task automatic test_drop();
      int lat;
      logic [1:0] rv, ra;
      logic [127:0] own, oth;
      run_txn(0, 0, 16'h0100, '0, 3, lat, rv, own, oth, ra);
      if (lat !== 26 || rv !== 2'b01) begin
         failures++; $display("FAIL drop_resp got=lat%0d/resp%b exp=lat26/resp01", lat, rv);
      end
      checks++;
      if (own !== PAT_A5) begin
         failures++; $display("FAIL drop_data got=%h exp=%h", own, PAT_A5);
      end
      checks++;
   endtask

   initial begin
      idle_bus();
      rst = 1'b1;
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_reset_mid_write();
      test_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
